// File: rtl/riscv_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } loader_state_e;

    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] base,
                                                  input logic [15:0]     idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four stream bytes into a little-endian word and strobes it for one cycle.
module byte_packer
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            fire_i,
    input  logic [7:0]      byte_i,
    output logic [1:0]      lane_o,
    output logic [XLEN-1:0] word_o,
    output logic            word_valid_o
);

    logic [1:0]      lane_q, lane_d;
    logic [23:0]     shift_q, shift_d;
    logic [XLEN-1:0] word_q, word_d;
    logic            valid_q, valid_d;

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            lane_d  = 2'd0;
            shift_d = 24'd0;
        end else if (fire_i) begin
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
                // Earlier lanes sit in the low bytes, so the 4th byte lands on top.
                word_d  = {byte_i, shift_q};
                valid_d = 1'b1;
                shift_d = 24'd0;
            end else begin
                shift_d = {byte_i, shift_q[23:8]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign lane_o       = lane_q;
    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes words
// to instruction memory and releases the core reset once the checksum verifies.
// Handshake: a byte moves on a rising edge where byte_valid_i && byte_ready_o; the
// source holds byte_data_i stable while byte_valid_i is high and not yet accepted.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int              DEPTH_WORDS = 256,
    parameter logic [XLEN-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_data_i,
    output logic            byte_ready_o,
    output logic            imem_we_o,
    output logic [XLEN-1:0] imem_waddr_o,
    output logic [XLEN-1:0] imem_wdata_o,
    output logic            core_rst_o,
    output logic            done_o,
    output logic            error_o,
    output logic [15:0]     word_count_o,
    output logic [2:0]      state_o
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    loader_state_e   state_q;
    logic [15:0]     len_q;
    logic [7:0]      csum_q;
    logic [15:0]     wcount_q;
    logic [XLEN-1:0] waddr_q;
    logic            core_rst_q;
    logic            done_q;
    logic            error_q;

    logic        fire;
    logic        restart;
    logic [15:0] len_full;
    logic [1:0]  lane;

    assign byte_ready_o = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                          (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign fire         = byte_valid_i && byte_ready_o;
    assign restart      = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                      (state_q == ST_ERR));
    assign len_full     = {byte_data_i, len_q[7:0]};

    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (restart),
        .fire_i       (fire && (state_q == ST_DATA)),
        .byte_i       (byte_data_i),
        .lane_o       (lane),
        .word_o       (imem_wdata_o),
        .word_valid_o (imem_we_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            len_q      <= 16'd0;
            csum_q     <= 8'd0;
            wcount_q   <= 16'd0;
            waddr_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        state_q    <= ST_LEN0;
                        wcount_q   <= 16'd0;
                        csum_q     <= 8'd0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        core_rst_q <= 1'b1;
                    end
                end
                ST_LEN0: begin
                    if (fire) begin
                        len_q[7:0] <= byte_data_i;
                        state_q    <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (fire) begin
                        len_q[15:8] <= byte_data_i;
                        if ({1'b0, len_full} > DEPTH_L) begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state_q <= ST_CSUM;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (fire) begin
                        csum_q <= csum_q ^ byte_data_i;
                        // The packer strobes the word next cycle; address and count move with it.
                        if (lane == 2'd3) begin
                            waddr_q  <= word_addr(BASE_ADDR, wcount_q);
                            wcount_q <= wcount_q + 16'd1;
                            if (wcount_q + 16'd1 == len_q) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (fire) begin
                        if (byte_data_i == csum_q) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_waddr_o = waddr_q;
    assign core_rst_o   = core_rst_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign word_count_o = wcount_q;
    assign state_o      = state_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. While it holds the core in reset, it accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive instruction-memory addresses. On a verified load it releases the core reset so PC starts fetching from `BASE_ADDR`. It sits between the host/debug byte source and the write port of `inst_mem`; the core's own fetch path is the reader of what this block writes.

## Interface
- `DEPTH_WORDS`, 256: instruction-memory capacity in words; larger loads are rejected.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `byte_valid`  in  1: source has a byte.
- `byte_data`  in  8: stream byte.
- `byte_ready`  out  1: loader accepts the byte this cycle.
- `imem_we`  out  1: instruction-memory write strobe, one cycle per word.
- `imem_waddr`  out  32: byte address, `BASE_ADDR + 4*index`.
- `imem_wdata`  out  32: assembled word.
- `core_rst`  out  1: active-high reset to PC/core.
- `done`  out  1: load verified, core running.
- `error`  out  1: length overflow or checksum mismatch.
- `word_count`  out  16: words written in the current/last load.

## Operation
- Stream format:
  - LEN0, LEN1: word count N, little-endian, 16 bits.
  - 4N payload bytes, little-endian per word.
  - One checksum byte: XOR of all payload bytes. Length bytes are excluded.
- A byte transfers only when `byte_valid && byte_ready`.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: `start` → LEN0.
  - LEN0 → LEN1 on a transfer.
  - LEN1 on a transfer:
    - N > `DEPTH_WORDS` → ERR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA: each transfer shifts the byte into lane `byte_idx` (0..3) and XORs it into the checksum accumulator. On the lane-3 transfer the word is registered for writing. After the N-th word → CSUM.
  - CSUM: on a transfer, byte == accumulator → DONE, else → ERR.
  - DONE and ERR: `start` → LEN0. This clears `word_count`, `byte_idx`, the accumulator, `done` and `error`, and reasserts `core_rst`.
- `byte_ready` = 1 exactly in LEN0, LEN1, DATA and CSUM. No back-pressure is generated; writes never stall the stream.
- `start` in any receive state is ignored.
- `word_count` increments with each `imem_we` and saturates by construction at N.
- Address arithmetic is 32-bit modulo. `word_count` is 16-bit.

## Timing
- Reset values:
  - State = IDLE.
  - `core_rst` = 1.
  - `byte_ready`, `imem_we`, `done`, `error` = 0.
  - `imem_waddr`, `imem_wdata`, `word_count` = 0.
- `imem_we` pulses the cycle after the lane-3 transfer, with `imem_waddr`/`imem_wdata` valid in that same cycle. Back-to-back words produce `imem_we` on consecutive cycles.
- The last word's write strobe occurs no later than the CSUM byte transfer, so every write completes before `core_rst` falls.
- CSUM transfer at edge k:
  - Match: `done` = 1 and `core_rst` = 0 from edge k+1.
  - Mismatch: `error` = 1 and `core_rst` stays 1.
- After a `start` pulse at edge k, `core_rst` = 1 and `byte_ready` = 1 from edge k+1.
- Reset asserted mid-load: all outputs return to reset values immediately (asynchronously). The partial load is abandoned, and memory contents are undefined-but-harmless because the core stays in reset.

## Structure
- Shared package `riscv_pkg`: loader state enum, `XLEN` = 32, the default `BASE_ADDR` constant.
- One natural sub-module, `byte_packer`: byte lane counter, 32-bit little-endian shift assembly, and the word-complete strobe.
- The FSM, checksum and address generation stay in `imem_loader`.

## Test plan
- One-word load: `start`, then 01 00, 13 05 A0 00, B6.
  - `imem_we` fires once with addr 0x0, data 0x00A00513.
  - `done` = 1, `core_rst` = 0, `word_count` = 1.
- Back-pressure-free burst: N = 3 with `byte_valid` held high.
  - Three `imem_we` pulses at addrs 0x0, 0x4, 0x8, each one cycle after its 4th byte.
  - Checksum correct → `done`.
- Bad checksum: same stream as the one-word load with final byte B7.
  - Word still written; `error` = 1, `done` = 0, `core_rst` stays 1.
  - A following `start` plus a valid stream → `done`.
- Overflow and empty:
  - N = 0x0101 with `DEPTH_WORDS` = 256 → ERR right after LEN1, no `imem_we`.
  - N = 0 followed by checksum 00 → `done`, `word_count` = 0.
- Stall/ignore: `byte_valid` toggled randomly with `start` pulsed mid-DATA.
  - Load result is unchanged; `start` is ignored.
- Reset mid-DATA: assert `rst` = 0 after 6 payload bytes.
  - All outputs return to reset values at once.
  - After release, state is IDLE and `core_rst` = 1.
